exec_wb_stage: RTL and testbench
================================

# exec_wb_stage

Execute/write-back stage of processor Z, directly downstream of the fetch/decode stage. Each cycle it consumes one decoded instruction (icode, ifun, rA, rB, valC), reads the six-entry 32-bit register file, performs IRMOV/ADD/SUB/AND/XOR, and writes the result back one cycle later. It also maintains condition codes, a sticky illegal-instruction flag, and a retired-instruction counter.

## Interface
- NREGS, 6: architectural registers %r0..%r5
- DW, 32: data width
- CNTW, 16: retired-counter width
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  decoded fields valid this cycle (driven by `working`, delayed one cycle)
- icode  in  4  instruction code
- ifun  in  4  function code
- rA  in  4  source register ID
- rB  in  4  source/destination register ID
- valC  in  16  immediate
- wb_valid  out  1  write-back in progress this cycle
- wb_dst  out  4  write-back register ID; 0xF = none
- wb_val  out  DW  write-back value
- cc  out  3  {ZF, SF, OF}
- err  out  1  sticky illegal-instruction flag
- retired  out  CNTW  count of retired instructions
- dbg_sel  in  3  debug read select
- dbg_dat  out  DW  combinational read of regfile[dbg_sel]; 0 when dbg_sel > 5

## Operation
- Encoding: icode 0 or 1 = NOP; icode 3 = IRMOV (ifun 0, rA 0xF); icode 6 = OP (ifun 0 ADD, 1 SUB, 2 AND, 3 XOR).
- IRMOV: rB ← zero-extended valC.
- OP: rB ← valB op valA, with SUB = valB − valA. Arithmetic is modulo 2^32.
- Illegal instruction: icode not in {0,1,3,6}; ifun > 3 for OP; ifun ≠ 0 for IRMOV; rB > 5; rA > 5 for OP.
  - Effects: no write, no cc change, err ← 1 (sticky until reset), retired unchanged.
- NOP: no effect; not counted in retired.
- in_valid low: inputs ignored.
- Flags (OP only; IRMOV leaves cc unchanged):
  - ZF = (result == 0); SF = result[31].
  - OF, ADD: both operands share a sign that differs from the result's.
  - OF, SUB: valB and valA differ in sign and the result's sign differs from valB's.
  - OF, AND/XOR: 0.
- Pipeline: E register {e_valid, e_dst, e_val} loads at the end of the sampling cycle. The regfile write from E occurs at the next edge.
- Forwarding: an operand read whose ID equals e_dst while e_valid is set takes e_val, not the regfile. Required so back-to-back dependent instructions see the newest value.
- Forwarding is also applied to dbg_dat.

## Timing
- Instruction sampled at edge ending cycle N:
  - cycle N+1: wb_valid=1, wb_dst, wb_val; cc and err updated.
  - edge ending N+1: regfile written; retired += 1 (wraps at 2^CNTW).
- Throughput: one instruction per cycle, no stalls.
- Reset (reset_n low at an edge):
  - all regs 0; E register cleared.
  - wb_valid=0, wb_dst=0xF, wb_val=0, cc=3'b000, err=0, retired=0.
  - Pending write-back discarded (reset mid-operation loses the in-flight result).
- Reset has priority over in_valid.

## Configuration
- EXEC_CC_EN defined: cc computed and updated as above.
- EXEC_CC_EN undefined: flag logic omitted; cc tied to 3'b000; all other behaviour unchanged.

## Structure
- Package exec_pkg holds:
  - ICODE_NOP0/NOP1/IRMOV/OP
  - IFUN_ADD/SUB/AND/XOR
  - REG_NONE = 4'hF
  - CC_ZF/CC_SF/CC_OF bit indices
- Sub-module exec_alu: combinational, inputs (ifun, valA, valB), outputs (result, zf, sf, of).
- Regfile, forwarding, E register and counters live in exec_wb_stage.

## Test plan
- IRMOV 0x30F21234 → N+1: wb_dst=2, wb_val=0x00001234; from N+2: dbg_sel=2 gives 0x00001234; retired=1; cc unchanged.
- Back-to-back 0x30F00007, 0x30F10005, 0x61100000 (SUB r1 from r0) → r0=2, cc=000; proves forwarding on consecutive cycles.
- IRMOV r0,0x8000, then 16× ADD r0,r0 (0x60000000) → 16th result 0x80000000 with SF=1, OF=1, ZF=0; 17th gives 0, ZF=1, OF=1.
- Illegal 0x30F60001 (rB=6) then 0x65000000 (ifun 5) → no regfile change, err=1 and stays 1, retired unchanged, cc unchanged.
- in_valid=0 with 0x30F3FFFF on inputs, and icode 0 with in_valid=1 → r3 unchanged, retired unchanged, wb_valid=0.
- IRMOV r4,0xBEEF sampled, reset_n low the next cycle → r4=0, retired=0, wb_dst=0xF, err=0, cc=000.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings and decode helper for the execute/write-back stage.
package exec_pkg;

  localparam int EXEC_NREGS = 6;
  localparam int EXEC_DW    = 32;
  localparam int EXEC_CNTW  = 16;

  localparam logic [3:0] ICODE_NOP0  = 4'h0;
  localparam logic [3:0] ICODE_NOP1  = 4'h1;
  localparam logic [3:0] ICODE_IRMOV = 4'h3;
  localparam logic [3:0] ICODE_OP    = 4'h6;

  localparam logic [3:0] IFUN_ADD = 4'h0;
  localparam logic [3:0] IFUN_SUB = 4'h1;
  localparam logic [3:0] IFUN_AND = 4'h2;
  localparam logic [3:0] IFUN_XOR = 4'h3;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Bit positions inside cc = {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // What a sampled instruction does to architectural state
  typedef enum logic [1:0] {
    CLS_NONE    = 2'd0,
    CLS_IRMOV   = 2'd1,
    CLS_OP      = 2'd2,
    CLS_ILLEGAL = 2'd3
  } instr_cls_t;

  // Classify a decoded instruction; anything not explicitly legal is illegal
  function automatic instr_cls_t classify(input logic [3:0] icode,
                                          input logic [3:0] ifun,
                                          input logic [3:0] ra,
                                          input logic [3:0] rb);
    instr_cls_t cls;
    cls = CLS_ILLEGAL;
    case (icode)
      ICODE_NOP0, ICODE_NOP1: cls = CLS_NONE;
      ICODE_IRMOV: begin
        if (ifun == IFUN_ADD && rb < 4'(EXEC_NREGS)) cls = CLS_IRMOV;
      end
      ICODE_OP: begin
        if (ifun <= IFUN_XOR && ra < 4'(EXEC_NREGS) && rb < 4'(EXEC_NREGS))
          cls = CLS_OP;
      end
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: result = valB op valA, plus zero/sign/overflow flags.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DW = EXEC_DW
) (
  input  logic [3:0]    ifun,
  input  logic [DW-1:0] valA,
  input  logic [DW-1:0] valB,
  output logic [DW-1:0] result,
  output logic          zf,
  output logic          sf,
  output logic          of
);

  // Operation select; overflow is only meaningful for ADD and SUB
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (ifun)
      IFUN_ADD: begin
        result = valB + valA;
        of     = (valA[DW-1] == valB[DW-1]) && (result[DW-1] != valB[DW-1]);
      end
      IFUN_SUB: begin
        result = valB - valA;
        of     = (valA[DW-1] != valB[DW-1]) && (result[DW-1] != valB[DW-1]);
      end
      IFUN_AND: result = valB & valA;
      IFUN_XOR: result = valB ^ valA;
      default:  result = '0;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[DW-1];

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage: register file, forwarding, E register,
// sticky error flag and retired counter.
// Optional feature macro: EXEC_CC_EN (condition codes; cc reads 3'b000 without it).
//
// Input handshake: in_valid qualifies icode/ifun/rA/rB/valC for exactly the
// cycle it is high; there is no ready, the stage accepts one instruction per
// cycle and never stalls.
module exec_wb_stage
  import exec_pkg::*;
#(
  parameter int NREGS = EXEC_NREGS,
  parameter int DW    = EXEC_DW,
  parameter int CNTW  = EXEC_CNTW
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [3:0]      icode,
  input  logic [3:0]      ifun,
  input  logic [3:0]      rA,
  input  logic [3:0]      rB,
  input  logic [15:0]     valC,
  output logic            wb_valid,
  output logic [3:0]      wb_dst,
  output logic [DW-1:0]   wb_val,
  output logic [2:0]      cc,
  output logic            err,
  output logic [CNTW-1:0] retired,
  input  logic [2:0]      dbg_sel,
  output logic [DW-1:0]   dbg_dat
);

  logic [DW-1:0] regs [NREGS];

  // E register: the result produced last cycle, written to regs next edge
  logic          e_valid;
  logic [3:0]    e_dst;
  logic [DW-1:0] e_val;

  instr_cls_t    cls;
  logic [DW-1:0] rf_a, rf_b, val_a, val_b;
  logic [DW-1:0] alu_res;
  logic          alu_zf, alu_sf, alu_of;

  assign cls = in_valid ? classify(icode, ifun, rA, rB) : CLS_NONE;

  // Register reads, out-of-range IDs read as zero (such instructions are illegal)
  assign rf_a = (rA < 4'(NREGS)) ? regs[rA[2:0]] : '0;
  assign rf_b = (rB < 4'(NREGS)) ? regs[rB[2:0]] : '0;

  // The E register holds a value newer than the regfile for e_dst
  assign val_a = (e_valid && e_dst == rA) ? e_val : rf_a;
  assign val_b = (e_valid && e_dst == rB) ? e_val : rf_b;

  exec_alu #(.DW(DW)) u_alu (
    .ifun   (ifun),
    .valA   (val_a),
    .valB   (val_b),
    .result (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Debug read sees the same forwarded view as the operand reads
  always_comb begin
    dbg_dat = '0;
    if (dbg_sel < 3'(NREGS)) begin
      if (e_valid && e_dst == {1'b0, dbg_sel}) dbg_dat = e_val;
      else                                     dbg_dat = regs[dbg_sel];
    end
  end

  // Regfile: commit the E register one edge after the instruction was sampled
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (e_valid) begin
      regs[e_dst[2:0]] <= e_val;
    end
  end

  // E register load, sticky error and retire counting
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      e_valid <= 1'b0;
      e_dst   <= REG_NONE;
      e_val   <= '0;
      err     <= 1'b0;
      retired <= '0;
    end else begin
      retired <= retired + CNTW'(e_valid);
      case (cls)
        CLS_IRMOV: begin
          e_valid <= 1'b1;
          e_dst   <= rB;
          e_val   <= DW'(valC);
        end
        CLS_OP: begin
          e_valid <= 1'b1;
          e_dst   <= rB;
          e_val   <= alu_res;
        end
        default: begin
          e_valid <= 1'b0;
          e_dst   <= REG_NONE;
          e_val   <= '0;
        end
      endcase
      if (cls == CLS_ILLEGAL) err <= 1'b1;
    end
  end

  assign wb_valid = e_valid;
  assign wb_dst   = e_dst;
  assign wb_val   = e_val;

`ifdef EXEC_CC_EN
  logic [2:0] cc_q;

  // Condition codes follow OP results only
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cc_q <= 3'b000;
    end else if (cls == CLS_OP) begin
      cc_q[CC_ZF] <= alu_zf;
      cc_q[CC_SF] <= alu_sf;
      cc_q[CC_OF] <= alu_of;
    end
  end

  assign cc = cc_q;
`else
  logic unused_flags;
  assign unused_flags = alu_zf ^ alu_sf ^ alu_of;
  assign cc = 3'b000;
`endif

endmodule

// File: tb/tb_exec_wb_stage.sv
// Self-checking bench for exec_wb_stage: directed scenarios with literal
// expectations, then randomized instructions against an architectural model.
module tb_exec_wb_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = '0, ifun = '0, rA = '0, rB = '0;
  logic [15:0] valC = '0;
  logic [2:0]  dbg_sel = '0;
  logic        wb_valid;
  logic [3:0]  wb_dst;
  logic [31:0] wb_val;
  logic [2:0]  cc;
  logic        err;
  logic [15:0] retired;
  logic [31:0] dbg_dat;

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 1'b0;

  // Architectural model: registers as a program sees them after each instruction
  logic [31:0] m_regs [6];
  logic [2:0]  m_cc = 3'b000;
  bit          m_err = 1'b0;
  logic [15:0] m_accepted = '0;
  logic [15:0] m_retired = '0;
  logic [35:0] exp_q[$];

  // clock/reset block
  always #5 clock = ~clock;

  exec_wb_stage dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .icode    (icode),
    .ifun     (ifun),
    .rA       (rA),
    .rB       (rB),
    .valC     (valC),
    .wb_valid (wb_valid),
    .wb_dst   (wb_dst),
    .wb_val   (wb_val),
    .cc       (cc),
    .err      (err),
    .retired  (retired),
    .dbg_sel  (dbg_sel),
    .dbg_dat  (dbg_dat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Apply one sampled instruction (or reset) to the architectural model
  task automatic model_step();
    logic [31:0] a, b, res;
    longint      sa, sb, wide;
    bit          of;
    exp_q.delete();
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) m_regs[i] = '0;
      m_cc = 3'b000;
      m_err = 1'b0;
      m_accepted = '0;
      m_retired = '0;
      return;
    end
    m_retired = m_accepted;
    if (!in_valid) return;
    if (icode == 4'd0 || icode == 4'd1) return;
    if (icode == 4'd3) begin
      if (ifun != 0 || rB > 5) begin m_err = 1'b1; return; end
      m_regs[rB] = {16'h0, valC};
      exp_q.push_back({rB, 16'h0, valC});
      m_accepted++;
      return;
    end
    if (icode == 4'd6) begin
      if (ifun > 3 || rA > 5 || rB > 5) begin m_err = 1'b1; return; end
      a = m_regs[rA];
      b = m_regs[rB];
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      wide = 0;
      res = '0;
      case (ifun)
        4'd0: begin res = b + a; wide = sb + sa; end
        4'd1: begin res = b - a; wide = sb - sa; end
        4'd2: res = b & a;
        default: res = b ^ a;
      endcase
      of = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      m_cc = {res == 32'h0, res[31], of};
      m_regs[rB] = res;
      exp_q.push_back({rB, res});
      m_accepted++;
      return;
    end
    m_err = 1'b1;
  endtask

  // driver task: hold inputs for one cycle, then advance the model
  task automatic step(input bit rn, input bit v, input logic [31:0] w, input logic [2:0] ds);
    reset_n  = rn;
    in_valid = v;
    icode    = w[31:28];
    ifun     = w[27:24];
    rA       = w[23:20];
    rB       = w[19:16];
    valC     = w[15:0];
    dbg_sel  = ds;
    @(posedge clock);
    #1;
    model_step();
    check_en = 1'b1;
  endtask

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clock) begin
    logic [35:0] e;
    if (check_en) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_dst", 32'(wb_dst), 32'(e[35:32]));
        chk("wb_val", wb_val, e[31:0]);
      end else begin
        chk("wb_idle_valid", 32'(wb_valid), 32'd0);
        chk("wb_idle_dst", 32'(wb_dst), 32'hF);
      end
`ifdef EXEC_CC_EN
      chk("cc", 32'(cc), 32'(m_cc));
`else
      chk("cc", 32'(cc), 32'd0);
`endif
      chk("err", 32'(err), 32'(m_err));
      chk("retired", 32'(retired), 32'(m_retired));
      chk("dbg_dat", dbg_dat, (dbg_sel < 3'd6) ? m_regs[dbg_sel] : 32'h0);
    end
  end

  logic [2:0] cc_add16, cc_add17;

  initial begin
    logic [31:0] w;
    int kind;
`ifdef EXEC_CC_EN
    cc_add16 = 3'b011;
    cc_add17 = 3'b101;
`else
    cc_add16 = 3'b000;
    cc_add17 = 3'b000;
`endif
    for (int i = 0; i < 6; i++) m_regs[i] = '0;

    // reset
    step(1'b0, 1'b0, 32'h0, 3'd0);
    step(1'b0, 1'b1, 32'h30F21234, 3'd0);
    chk("rst_wb_dst", 32'(wb_dst), 32'hF);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // IRMOV r2
    step(1'b1, 1'b1, 32'h30F21234, 3'd2);
    chk("irmov_dst", 32'(wb_dst), 32'd2);
    chk("irmov_val", wb_val, 32'h00001234);
    chk("irmov_cc", 32'(cc), 32'd0);
    step(1'b1, 1'b1, 32'h00000000, 3'd2);
    chk("irmov_dbg", dbg_dat, 32'h00001234);
    chk("irmov_retired", 32'(retired), 32'd1);
    chk("irmov_nop_wb", 32'(wb_valid), 32'd0);

    // back-to-back dependent instructions
    step(1'b1, 1'b1, 32'h30F00007, 3'd0);
    step(1'b1, 1'b1, 32'h30F10005, 3'd1);
    step(1'b1, 1'b1, 32'h61100000, 3'd0);
    chk("fwd_sub_val", wb_val, 32'd2);
    chk("fwd_sub_dbg", dbg_dat, 32'd2);
    chk("fwd_sub_cc", 32'(cc), 32'd0);
    chk("model_r0", m_regs[0], 32'd2);

    // overflow chain
    step(1'b1, 1'b1, 32'h30F08000, 3'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'h60000000, 3'd0);
    chk("add16_val", wb_val, 32'h80000000);
    chk("add16_cc", 32'(cc), 32'(cc_add16));
    chk("model_add16", m_regs[0], 32'h80000000);
    step(1'b1, 1'b1, 32'h60000000, 3'd0);
    chk("add17_val", wb_val, 32'h0);
    chk("add17_cc", 32'(cc), 32'(cc_add17));
    step(1'b1, 1'b0, 32'h0, 3'd0);
    chk("chain_retired", 32'(retired), 32'd22);

    // illegal instructions
    step(1'b1, 1'b1, 32'h30F60001, 3'd0);
    chk("ill1_err", 32'(err), 32'd1);
    step(1'b1, 1'b1, 32'h65000000, 3'd0);
    chk("ill2_wb", 32'(wb_valid), 32'd0);
    step(1'b1, 1'b1, 32'h10000000, 3'd0);
    chk("ill_err_sticky", 32'(err), 32'd1);
    chk("ill_retired", 32'(retired), 32'd22);
    chk("ill_cc", 32'(cc), 32'(cc_add17));
    chk("ill_r0", dbg_dat, 32'h0);

    // ignored inputs
    step(1'b1, 1'b0, 32'h30F3FFFF, 3'd3);
    chk("inv_wb", 32'(wb_valid), 32'd0);
    step(1'b1, 1'b1, 32'h00F3FFFF, 3'd3);
    chk("nop_wb", 32'(wb_valid), 32'd0);
    chk("nop_r3", dbg_dat, 32'h0);
    chk("nop_retired", 32'(retired), 32'd22);

    // reset discards in-flight result
    step(1'b1, 1'b1, 32'h30F4BEEF, 3'd4);
    chk("beef_fwd", dbg_dat, 32'h0000BEEF);
    step(1'b0, 1'b1, 32'h00000000, 3'd4);
    chk("midrst_r4", dbg_dat, 32'h0);
    chk("midrst_retired", 32'(retired), 32'd0);
    chk("midrst_dst", 32'(wb_dst), 32'hF);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_cc", 32'(cc), 32'd0);

    // randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      kind = $urandom_range(0, 9);
      w = $urandom();
      case (kind)
        0, 1, 2, 3: w = {4'h6, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 5)),
                         4'($urandom_range(0, 5)), 16'h0};
        4, 5:       w = {8'h30, 4'hF, 4'($urandom_range(0, 5)), w[15:0]};
        6:          w = {4'($urandom_range(0, 1)), w[27:0]};
        9:          w = {4'h6, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 7)),
                         4'($urandom_range(0, 7)), 16'h0};
        default: ;
      endcase
      step($urandom_range(0, 299) != 0, $urandom_range(0, 7) != 0, w,
           3'($urandom_range(0, 7)));
    end
    step(1'b1, 1'b0, 32'h0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
